add_16bit_signed_serial: RTL and testbench

//   Multi-cycle, digit-serial two's-complement adder: result = A + B, with a signed overflow flag.
//   It is the inverse-direction companion to the 16-bit signed subtractor.
//   It sits in the arithmetic datapath wherever area matters more than latency.

---
 rtl/add_16bit_signed_serial_pkg.sv | 19 +
 rtl/add_16bit_signed_serial_if.sv | 29 ++
 rtl/add_16bit_signed_serial_digit.sv | 15 +
 rtl/add_16bit_signed_serial.sv | 110 +++++++++++
 tb/tb_add_16bit_signed_serial.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/add_16bit_signed_serial_pkg.sv
// Shared types and helpers for the digit-serial signed adder.
// Holds the FSM state encoding, default geometry and the signed overflow rule.
package add_16bit_signed_serial_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement overflow: operands agree in sign but the sum does not.
  function automatic logic sadd_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_16bit_signed_serial_if.sv
// Operand/result handshake bundle for the digit-serial signed adder.
// The master drives operands and out_ready; the slave (adder) drives the rest.
interface add_16bit_signed_serial_if
  import add_16bit_signed_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             carry_out;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, result, overflow, carry_out
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, result, overflow, carry_out
  );

endinterface

// File: rtl/add_16bit_signed_serial_digit.sv
// DIGIT_W-bit combinational adder with carry in/out.
// One instance is time-shared across all digits of the serial adder.
module add_digit_cin #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_cin,
  output logic [DIGIT_W-1:0] o_sum,
  output logic               o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_cin};

endmodule

// File: rtl/add_16bit_signed_serial.sv
// Digit-serial two's-complement adder: result = A + B over WIDTH/DIGIT_W cycles,
// with signed overflow and unsigned carry-out, behind valid/ready handshakes.
module add_16bit_signed_serial
  import add_16bit_signed_serial_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  add_16bit_signed_serial_if.slave     bus,
  output state_t                       o_state
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  generate
    if ((WIDTH % DIGIT_W) != 0) begin : g_bad_geometry
      $error("WIDTH must be a multiple of DIGIT_W");
    end
  endgenerate

  state_t             r_state;
  logic [CNT_W-1:0]   r_dig;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [WIDTH-1:0]   r_result;
  logic               r_overflow;
  logic               r_carry_out;
  logic               r_out_valid;
  logic               r_in_ready;

  logic [DIGIT_W-1:0] w_a_dig;
  logic [DIGIT_W-1:0] w_b_dig;
  logic [DIGIT_W-1:0] w_sum;
  logic               w_cout;

  assign w_a_dig = r_a[r_dig*DIGIT_W +: DIGIT_W];
  assign w_b_dig = r_b[r_dig*DIGIT_W +: DIGIT_W];

  add_digit_cin #(.DIGIT_W(DIGIT_W)) u_digit (
    .i_a    (w_a_dig),
    .i_b    (w_b_dig),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid, once raised, holds with stable data until that edge, and nothing is queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dig       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_carry_out <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.A;
            r_b        <= bus.B;
            r_carry    <= 1'b0;
            r_dig      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_result[r_dig*DIGIT_W +: DIGIT_W] <= w_sum;
          r_carry <= w_cout;
          if (r_dig == LAST_DIG) begin
            // The top digit carries the operand and sum sign bits.
            r_overflow  <= sadd_ovf(w_a_dig[DIGIT_W-1], w_b_dig[DIGIT_W-1], w_sum[DIGIT_W-1]);
            r_carry_out <= w_cout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_dig <= r_dig + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.overflow  = r_overflow;
  assign bus.carry_out = r_carry_out;
  assign o_state       = r_state;

endmodule

// File: tb/tb_add_16bit_signed_serial.sv
// Bench for the digit-serial signed adder: directed corner cases, backpressure,
// mid-operation reset and randomized traffic against an arithmetic reference.
module tb_add_16bit_signed_serial;
  import add_16bit_signed_serial_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  add_16bit_signed_serial_if #(.WIDTH(16)) bus ();

  add_16bit_signed_serial #(.WIDTH(16), .DIGIT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];

  // {overflow, carry_out, result} from plain integer arithmetic.
  function automatic logic [17:0] golden(input logic [15:0] a, input logic [15:0] b);
    int          sa;
    int          sb;
    int          ss;
    logic [16:0] u;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ss = sa + sb;
    u  = {1'b0, a} + {1'b0, b};
    return {(ss > 32767 || ss < -32768), u[16], u[15:0]};
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = 16'($urandom);
    bus.B = 16'($urandom);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.A = 16'h0;
    bus.B = 16'h0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.out_valid, bus.overflow, bus.carry_out, bus.result} !== 19'h0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b o=%b c=%b r=%h want all zero",
               bus.out_valid, bus.overflow, bus.carry_out, bus.result);
    end
    total++;
    if (dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state got %s want IDLE", dbg_state.name());
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'd100, 16'h7FFF, 16'h8000, 16'hFFFB, 16'hFFFF};
    logic [15:0] tb [5] = '{16'd23,  16'h0001, 16'hFFFF, 16'h0003, 16'h0001};
    logic [17:0] te [5] = '{{2'b00, 16'd123}, {2'b10, 16'h8000}, {2'b11, 16'h7FFF},
                            {2'b00, 16'hFFFE}, {2'b01, 16'h0000}};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      send(ta[i], tb[i]);
      wait_out(cyc);
      total++;
      if (cyc !== 4) begin
        bad++;
        $display("FAIL directed_latency[%0d] got %0d cycles want 4", i, cyc);
      end
      total++;
      if ({bus.overflow, bus.carry_out, bus.result} !== te[i]) begin
        bad++;
        $display("FAIL directed_sum[%0d] %h+%h got o=%b c=%b r=%h want o=%b c=%b r=%h",
                 i, ta[i], tb[i], bus.overflow, bus.carry_out, bus.result,
                 te[i][17], te[i][16], te[i][15:0]);
      end
      release_out();
      total++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        bad++;
        $display("FAIL directed_release[%0d] got v=%b rdy=%b want v=0 rdy=1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int extra;
    send(16'h1111, 16'h2222);
    wait_out(cyc);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.A = 16'($urandom);
      bus.B = 16'($urandom);
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.in_ready, bus.overflow, bus.carry_out, bus.result} !==
          {4'b1000, 16'h3333}) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%b rdy=%b o=%b c=%b r=%h want v=1 rdy=0 o=0 c=0 r=3333",
                 i, bus.out_valid, bus.in_ready, bus.overflow, bus.carry_out, bus.result);
      end
    end
    bus.in_valid = 1'b0;
    release_out();
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid || dbg_state != IDLE) extra++;
      @(negedge clk);
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL bp_single_transfer got %0d busy cycles after release want 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int spurious;
    send(16'h7777, 16'h1111);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (dbg_state !== RUN) begin
      bad++;
      $display("FAIL midrst_pre_state got %s want RUN", dbg_state.name());
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({dbg_state, bus.out_valid, bus.overflow, bus.carry_out, bus.result} !== {IDLE, 19'h0}) begin
      bad++;
      $display("FAIL midrst_clear got st=%s v=%b o=%b c=%b r=%h want IDLE and zeros",
               dbg_state.name(), bus.out_valid, bus.overflow, bus.carry_out, bus.result);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) spurious++;
    end
    total++;
    if (spurious !== 0) begin
      bad++;
      $display("FAIL midrst_no_output got %0d valid cycles want 0", spurious);
    end
    send(16'h1234, 16'h0001);
    wait_out(cyc);
    total++;
    if ({bus.out_valid, bus.result} !== {1'b1, 16'h1235}) begin
      bad++;
      $display("FAIL midrst_next_op got v=%b r=%h want v=1 r=1235", bus.out_valid, bus.result);
    end
    release_out();
  endtask

  task automatic test_random(input int n_ops);
    logic [15:0] edges [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
    logic [15:0] a;
    logic [15:0] b;
    logic [17:0] exp_v;
    int          cyc;
    for (int i = 0; i < n_ops; i++) begin
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
      exp_q.push_back(golden(a, b));
      send(a, b);
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
      end
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if ({bus.out_valid, bus.overflow, bus.carry_out, bus.result} !== {1'b1, exp_v} || cyc !== 4) begin
        bad++;
        $display("FAIL random[%0d] %h+%h got v=%b o=%b c=%b r=%h lat=%0d want o=%b c=%b r=%h lat=4",
                 i, a, b, bus.out_valid, bus.overflow, bus.carry_out, bus.result, cyc,
                 exp_v[17], exp_v[16], exp_v[15:0]);
      end
      release_out();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
